// File: rtl/pwm_motor_driver.sv
// pwm_motor_driver
//   Turns the shared free-running PWM timebase into gated H-bridge drive for
//   one DC motor. The duty slews by at most RAMP_STEP per period, and a
//   direction reversal ramps the duty down to zero, then holds both legs low
//   for DEAD_PERIODS full periods before driving the other leg. Every command
//   is taken on a period boundary, so a pulse is never cut short or stretched.
//
// Ports
//   i_clk       system clock
//   i_reset     asynchronous, active-high reset
//   i_counter   timebase count, 0..PERIOD-1 (period end at PERIOD-1)
//   i_enable    run request           (sampled at period end only)
//   i_dir       0 = A/forward, 1 = B/reverse (sampled at period end only)
//   i_duty      target duty in clocks (sampled at period end, clamps to PERIOD)
//   o_pwm_a     forward bridge drive (registered, 1 clock after the compare)
//   o_pwm_b     reverse bridge drive (registered, 1 clock after the compare)
//   o_duty_now  duty applied to the current period
//   o_state     IDLE=0, RUN=1, STOP=2, DEAD=3
//   o_busy      high while in STOP or DEAD
//
// Handshake: there is no valid/ready pair; the period-end cycle
// (i_counter == PERIOD-1) acts as the single sampling strobe for i_enable,
// i_dir and i_duty, and every state/duty update lands on that clock edge.

module pwm_motor_driver #(
  parameter int PERIOD       = 1000,
  parameter int CNT_W        = 10,
  parameter int RAMP_STEP    = 10,
  parameter int DEAD_PERIODS = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [CNT_W-1:0] i_counter,
  input  logic             i_enable,
  input  logic             i_dir,
  input  logic [CNT_W-1:0] i_duty,
  output logic             o_pwm_a,
  output logic             o_pwm_b,
  output logic [CNT_W-1:0] o_duty_now,
  output logic [1:0]       o_state,
  output logic             o_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2,
    DEAD = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] PERIOD_V = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] LAST_V   = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] STEP_V   = CNT_W'(RAMP_STEP);
  localparam int               DEAD_W   = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_PERIODS - 1);

  state_t             state, state_n;
  logic [CNT_W-1:0]   duty, duty_n;
  logic               dir, dir_n;
  logic [DEAD_W-1:0]  dead, dead_n;

  logic               pe;
  logic [CNT_W-1:0]   target;
  logic [CNT_W-1:0]   ramp_next;
  logic [CNT_W-1:0]   down_next;
  logic [CNT_W-1:0]   first_duty;
  logic               driving;
  logic               raw;

  assign pe     = (i_counter == LAST_V);
  assign target = (i_duty > PERIOD_V) ? PERIOD_V : i_duty;

  // One ramp step toward target; the step shrinks to the remaining gap so
  // the duty lands exactly on target instead of overshooting it.
  always_comb begin
    if (target > duty) begin
      ramp_next = ((target - duty) > STEP_V) ? duty + STEP_V : target;
    end else begin
      ramp_next = ((duty - target) > STEP_V) ? duty - STEP_V : target;
    end
  end

  // One ramp step toward zero, saturating rather than wrapping.
  assign down_next  = (duty > STEP_V) ? duty - STEP_V : '0;
  assign first_duty = (target > STEP_V) ? STEP_V : target;

  // State register and datapath registers updated from the next-state logic.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= IDLE;
      duty  <= '0;
      dir   <= 1'b0;
      dead  <= '0;
    end else begin
      state <= state_n;
      duty  <= duty_n;
      dir   <= dir_n;
      dead  <= dead_n;
    end
  end

  always_comb begin
    state_n = state;
    duty_n  = duty;
    dir_n   = dir;
    dead_n  = dead;
    if (pe) begin
      case (state)
        IDLE: begin
          if (i_enable && (target != '0)) begin
            state_n = RUN;
            dir_n   = i_dir;
            duty_n  = first_duty;
          end
        end
        RUN: begin
          if (!i_enable || (i_dir != dir)) begin
            // Shutdown starts with the first down-step in this same edge; a
            // duty already at or below one step skips STOP entirely.
            duty_n  = down_next;
            dead_n  = '0;
            state_n = (down_next == '0) ? DEAD : STOP;
          end else begin
            duty_n = ramp_next;
          end
        end
        STOP: begin
          // Commands are ignored here: a stop always runs through DEAD.
          duty_n = down_next;
          if (down_next == '0) begin
            state_n = DEAD;
            dead_n  = '0;
          end
        end
        DEAD: begin
          duty_n = '0;
          if (dead == DEAD_LAST) begin
            dead_n = '0;
            dir_n  = i_dir;
            if (i_enable && (target != '0)) begin
              state_n = RUN;
              duty_n  = first_duty;
            end else begin
              state_n = IDLE;
            end
          end else begin
            dead_n = dead + DEAD_W'(1);
          end
        end
        default: begin
          state_n = IDLE;
          duty_n  = '0;
        end
      endcase
    end
  end

  // Full-scale duty drives high even on an out-of-range counter value, so
  // a duty of PERIOD really is a constant-high output.
  assign driving = (state == RUN) || (state == STOP);
  assign raw     = driving && ((duty == PERIOD_V) || (i_counter < duty));

  // Both legs come from one compare masked by a single direction bit, so
  // they can never be high together.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_pwm_a <= 1'b0;
      o_pwm_b <= 1'b0;
    end else begin
      o_pwm_a <= raw & ~dir;
      o_pwm_b <= raw & dir;
    end
  end

  assign o_duty_now = duty;
  assign o_state    = state;
  assign o_busy     = (state == STOP) || (state == DEAD);

endmodule

// File: tb/tb_pwm_motor_driver.sv
// tb_pwm_motor_driver
//   Drives the timebase counter and the command inputs, keeps a per-period
//   reference model of the motor driver, and compares every output every
//   clock plus the pulse width of every complete period. A shortened timebase
//   keeps the run short while keeping the same ramp and dead-time behaviour.

module tb_pwm_motor_driver;

  localparam int P    = 200;
  localparam int W    = 8;
  localparam int STEP = 10;
  localparam int DP   = 2;

  // ---------------- clock / reset ----------------
  logic         clk     = 1'b0;
  logic         reset   = 1'b1;
  logic [W-1:0] counter = '0;
  logic         enable  = 1'b0;
  logic         dir     = 1'b0;
  logic [W-1:0] duty    = '0;

  logic         pwm_a;
  logic         pwm_b;
  logic [W-1:0] duty_now;
  logic [1:0]   state;
  logic         busy;

  always #5 clk = ~clk;

  pwm_motor_driver #(
    .PERIOD(P), .CNT_W(W), .RAMP_STEP(STEP), .DEAD_PERIODS(DP)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_counter(counter),
    .i_enable(enable), .i_dir(dir), .i_duty(duty),
    .o_pwm_a(pwm_a), .o_pwm_b(pwm_b), .o_duty_now(duty_now),
    .o_state(state), .o_busy(busy)
  );

  // ---------------- scoreboard ----------------
  int tests_run = 0;
  int failed    = 0;

  // Reference model: 0 idle, 1 run, 2 stop, 3 dead
  int m_state = 0;
  int m_duty  = 0;
  int m_dir   = 0;
  int m_dead  = 0;

  // Pulse-width window for the period in progress
  bit win_ok = 1'b0;
  int win_a  = 0;
  int win_b  = 0;
  int cnt_a  = 0;
  int cnt_b  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Period-end rules written as plain integer arithmetic.
  task automatic model_pe(input bit en, input bit d, input int req);
    int tgt;
    tgt = imin(req, P);
    case (m_state)
      0: if (en && tgt > 0) begin
           m_dir = int'(d); m_state = 1; m_duty = imin(STEP, tgt);
         end
      1: if (!en || int'(d) != m_dir) begin
           m_duty  = imax(m_duty - STEP, 0);
           m_state = (m_duty == 0) ? 3 : 2;
           m_dead  = 0;
         end else if (tgt > m_duty) begin
           m_duty = imin(m_duty + STEP, tgt);
         end else begin
           m_duty = imax(m_duty - STEP, tgt);
         end
      2: begin
           m_duty = imax(m_duty - STEP, 0);
           if (m_duty == 0) begin m_state = 3; m_dead = 0; end
         end
      default: begin
           m_dead++;
           if (m_dead == DP) begin
             m_dead = 0;
             m_dir  = int'(d);
             if (en && tgt > 0) begin m_state = 1; m_duty = imin(STEP, tgt); end
             else m_state = 0;
           end
         end
    endcase
  endtask

  // ---------------- driver tasks ----------------
  // One clock: predict outputs from the pre-edge model, step the model on a
  // period end, compare after the edge, then advance the counter.
  task automatic cycle();
    int c;
    bit pe, en_s, dir_s, act, hi, exp_a, exp_b;
    int duty_s;
    c      = int'(counter);
    pe     = (c == P-1) && !reset;
    en_s   = enable;
    dir_s  = dir;
    duty_s = int'(duty);
    act    = (m_state == 1) || (m_state == 2);
    hi     = act && ((m_duty == P) || (c < m_duty));
    exp_a  = hi && (m_dir == 0);
    exp_b  = hi && (m_dir == 1);
    if (c == 0) begin
      win_ok = 1'b1;
      cnt_a  = 0;
      cnt_b  = 0;
      win_a  = (act && m_dir == 0) ? m_duty : 0;
      win_b  = (act && m_dir == 1) ? m_duty : 0;
    end
    if (c >= P) win_ok = 1'b0;
    @(posedge clk);
    #1;
    if (pe) model_pe(en_s, dir_s, duty_s);
    check("pwm_a", 32'(pwm_a), 32'(exp_a));
    check("pwm_b", 32'(pwm_b), 32'(exp_b));
    check("exclusive", 32'(pwm_a & pwm_b), 32'(0));
    check("duty_now", 32'(duty_now), 32'(m_duty));
    check("state", 32'(state), 32'(m_state));
    check("busy", 32'(busy), 32'(m_state >= 2));
    cnt_a += int'(pwm_a);
    cnt_b += int'(pwm_b);
    if (c == P-1 && win_ok) begin
      check("width_a", 32'(cnt_a), 32'(win_a));
      check("width_b", 32'(cnt_b), 32'(win_b));
    end
    counter = (c >= P-1) ? '0 : W'(c + 1);
  endtask

  task automatic run_pe(input int n);
    int seen;
    seen = 0;
    while (seen < n) begin
      if (int'(counter) == P-1 && !reset) seen++;
      cycle();
    end
  endtask

  task automatic run_to(input int x);
    while (int'(counter) != x) cycle();
  endtask

  task automatic model_reset();
    m_state = 0; m_duty = 0; m_dir = 0; m_dead = 0;
    win_ok  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, failed + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    #1;
    check("rst_state", 32'(state), 32'(0));
    check("rst_duty", 32'(duty_now), 32'(0));
    check("rst_pwm_a", 32'(pwm_a), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    repeat (3) cycle();
    reset = 1'b0;

    // Forward ramp 10, 20, ... up to 150
    enable = 1'b1; dir = 1'b0; duty = W'(150);
    run_pe(1);
    check("ramp_first", 32'(duty_now), 32'(10));
    check("ramp_run", 32'(state), 32'(1));
    run_pe(14);
    check("ramp_top", 32'(duty_now), 32'(150));
    run_pe(1);

    // Reversal: STOP down to 0, two DEAD periods, RUN on leg B
    dir = 1'b1;
    run_pe(1);
    check("rev_stop", 32'(state), 32'(2));
    check("rev_duty", 32'(duty_now), 32'(140));
    check("rev_busy", 32'(busy), 32'(1));
    run_pe(13);
    check("rev_low", 32'(duty_now), 32'(10));
    run_pe(1);
    check("rev_dead", 32'(state), 32'(3));
    run_pe(1);
    check("rev_dead2", 32'(state), 32'(3));
    run_pe(1);
    check("rev_run", 32'(state), 32'(1));
    check("rev_run_duty", 32'(duty_now), 32'(10));
    run_pe(14);
    check("rev_top", 32'(duty_now), 32'(150));

    // Clamp above full scale, out-of-range counter, then exact 195
    duty = W'(255);
    run_pe(5);
    check("clamp_full", 32'(duty_now), 32'(P));
    run_to(100);
    counter = W'(230);
    cycle();
    check("oor_high", 32'(pwm_b), 32'(1));
    run_pe(1);
    duty = W'(195);
    run_pe(1);
    check("clamp_down", 32'(duty_now), 32'(195));

    // Mid-period command change waits for the next period end
    run_to(100);
    duty = W'(50);
    run_to(150);
    check("mid_hold", 32'(duty_now), 32'(195));
    run_pe(1);
    check("mid_step", 32'(duty_now), 32'(185));

    // Asynchronous reset in the middle of a pulse
    run_to(50);
    check("pre_reset_b", 32'(pwm_b), 32'(1));
    #3 reset = 1'b1;
    #2;
    check("async_pwm_b", 32'(pwm_b), 32'(0));
    check("async_state", 32'(state), 32'(0));
    check("async_duty", 32'(duty_now), 32'(0));
    model_reset();
    repeat (3) cycle();
    reset = 1'b0;
    run_pe(1);
    check("restart_duty", 32'(duty_now), 32'(10));

    // Disable at 25: 15, 5, 0, DEAD x2, IDLE
    duty = W'(25);
    run_pe(2);
    check("small_top", 32'(duty_now), 32'(25));
    enable = 1'b0;
    run_pe(1);
    check("dis_15", 32'(duty_now), 32'(15));
    run_pe(1);
    check("dis_5", 32'(duty_now), 32'(5));
    run_pe(1);
    check("dis_dead", 32'(state), 32'(3));
    run_pe(1);
    check("dis_dead2", 32'(busy), 32'(1));
    run_pe(1);
    check("dis_idle", 32'(state), 32'(0));
    check("dis_busy", 32'(busy), 32'(0));

    // Randomized commands at random points in the period
    for (int i = 0; i < 40; i++) begin
      run_to(int'($urandom_range(0, P-1)));
      enable = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) dir = ~dir;
      duty = W'($urandom_range(0, 255));
      run_pe(1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
